memory_arbiter: RTL and testbench

Two-requester arbiter sharing the clip block RAMs (memory 0 / memory 1, single port, 1-cycle read latency) between the record path (write requests) and the playback path (read requests), so recording and playback can run concurrently. It sits between the deserializer/serializer-side sequencing and the two block RAM instances. It owns all RAM enable, write-enable, address and write-data pins, and returns registered read data tagged with a valid strobe.

---
 rtl/memory_arbiter.sv | 171 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the two single-port clip RAMs between record writes and playback reads.
// Optional macro WRITE_PRIORITY_EN: writes always win ties; otherwise ties alternate round-robin.
module memory_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 17,
  parameter int MAX_WAIT    = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   wr_req_i,
  input  logic                   wr_clip_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [WORD_LENGTH-1:0] wr_data_i,
  output logic                   wr_ack_o,
  input  logic                   rd_req_i,
  input  logic                   rd_clip_i,
  input  logic [ADDR_WIDTH-1:0]  rd_addr_i,
  output logic                   rd_ack_o,
  output logic [WORD_LENGTH-1:0] rd_data_o,
  output logic                   rd_valid_o,
  output logic                   mem_0_enable_o,
  output logic                   mem_1_enable_o,
  output logic                   mem_we_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic [WORD_LENGTH-1:0] mem_data_o,
  input  logic [WORD_LENGTH-1:0] mem_0_data_i,
  input  logic [WORD_LENGTH-1:0] mem_1_data_i,
  output logic                   timeout_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state_r;
  logic             last_grant_rd_r;
  logic             rd_pending_r;
  logic             rd_clip_r;
  logic [CNT_W-1:0] wr_wait_r;
  logic [CNT_W-1:0] rd_wait_r;
  logic             grant_wr_s;
  logic             wr_over_s;
  logic             rd_over_s;

  // Saturating count of cycles a request has been pending without an ack.
  function automatic logic [CNT_W-1:0] wait_next(input logic req, input logic ack,
                                                 input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] nxt;
    if (req && !ack) begin
      if (cnt == CNT_SAT) begin
        nxt = CNT_SAT;
      end else begin
        nxt = cnt + CNT_ONE;
      end
    end else begin
      nxt = CNT_ZERO;
    end
    return nxt;
  endfunction

  // Tie-break between simultaneous requests sampled in IDLE.
  always_comb begin
    grant_wr_s = 1'b0;
    if (wr_req_i && rd_req_i) begin
`ifdef WRITE_PRIORITY_EN
      grant_wr_s = 1'b1;
`else
      grant_wr_s = last_grant_rd_r;
`endif
    end else begin
      grant_wr_s = wr_req_i;
    end
  end

  assign wr_over_s = wr_req_i & ~wr_ack_o & (wr_wait_r >= CNT_LIMIT);
  assign rd_over_s = rd_req_i & ~rd_ack_o & (rd_wait_r >= CNT_LIMIT);

  // Arbitration FSM; the RAM strobes and acks are registered so they appear in the ACCESS cycle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_r         <= IDLE;
      mem_0_enable_o  <= 1'b0;
      mem_1_enable_o  <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= {ADDR_WIDTH{1'b0}};
      mem_data_o      <= {WORD_LENGTH{1'b0}};
      wr_ack_o        <= 1'b0;
      rd_ack_o        <= 1'b0;
      last_grant_rd_r <= 1'b1;
      rd_pending_r    <= 1'b0;
      rd_clip_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rd_pending_r <= 1'b0;
          if (wr_req_i || rd_req_i) begin
            state_r  <= ACCESS;
            mem_we_o <= grant_wr_s;
            wr_ack_o <= grant_wr_s;
            rd_ack_o <= ~grant_wr_s;
            if (grant_wr_s) begin
              mem_0_enable_o <= ~wr_clip_i;
              mem_1_enable_o <= wr_clip_i;
              mem_addr_o     <= wr_addr_i;
              mem_data_o     <= wr_data_i;
            end else begin
              mem_0_enable_o <= ~rd_clip_i;
              mem_1_enable_o <= rd_clip_i;
              mem_addr_o     <= rd_addr_i;
              rd_clip_r      <= rd_clip_i;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r         <= IDLE;
          last_grant_rd_r <= rd_ack_o;
          rd_pending_r    <= rd_ack_o;
          mem_0_enable_o  <= 1'b0;
          mem_1_enable_o  <= 1'b0;
          mem_we_o        <= 1'b0;
          wr_ack_o        <= 1'b0;
          rd_ack_o        <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          rd_pending_r   <= 1'b0;
          mem_0_enable_o <= 1'b0;
          mem_1_enable_o <= 1'b0;
          mem_we_o       <= 1'b0;
          wr_ack_o       <= 1'b0;
          rd_ack_o       <= 1'b0;
        end
      endcase
    end
  end

  // Read return: RAM output is valid the cycle after ACCESS and is captured on the next edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= {WORD_LENGTH{1'b0}};
    end else begin
      rd_valid_o <= rd_pending_r;
      if (rd_pending_r) begin
        rd_data_o <= rd_clip_r ? mem_1_data_i : mem_0_data_i;
      end else begin
        rd_data_o <= rd_data_o;
      end
    end
  end

  // Per-requester wait counters and the sticky timeout flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_wait_r <= CNT_ZERO;
      rd_wait_r <= CNT_ZERO;
      timeout_o <= 1'b0;
    end else begin
      wr_wait_r <= wait_next(wr_req_i, wr_ack_o, wr_wait_r);
      rd_wait_r <= wait_next(rd_req_i, rd_ack_o, rd_wait_r);
      timeout_o <= timeout_o | wr_over_s | rd_over_s;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed steps plus randomized traffic against a
// grant/latency reference model and a behavioural pair of block RAMs.
module tb_memory_arbiter;

  localparam int WL = 16;
  localparam int AW = 17;
  localparam int MAX_WAIT = 8;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          wr_req_i = 1'b0, wr_clip_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [WL-1:0] wr_data_i = '0;
  logic          rd_req_i = 1'b0, rd_clip_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          wr_ack_o, rd_ack_o, rd_valid_o, timeout_o;
  logic [WL-1:0] rd_data_o, mem_data_o;
  logic          mem_0_enable_o, mem_1_enable_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [WL-1:0] mem_0_data_i, mem_1_data_i;

  memory_arbiter #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .wr_req_i(wr_req_i), .wr_clip_i(wr_clip_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ack_o(wr_ack_o),
    .rd_req_i(rd_req_i), .rd_clip_i(rd_clip_i), .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .mem_0_enable_o(mem_0_enable_o), .mem_1_enable_o(mem_1_enable_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_0_data_i(mem_0_data_i), .mem_1_data_i(mem_1_data_i),
    .timeout_o(timeout_o)
  );

  always #5 clock_i = ~clock_i;

  // Behavioural single-port RAMs with one cycle of read latency.
  bit [WL-1:0] ram0 [0:(1<<AW)-1];
  bit [WL-1:0] ram1 [0:(1<<AW)-1];
  logic [WL-1:0] ram0_q = '0, ram1_q = '0;
  always @(posedge clock_i) begin
    if (mem_0_enable_o) begin
      if (mem_we_o) ram0[mem_addr_o] <= mem_data_o;
      else          ram0_q <= ram0[mem_addr_o];
    end
    if (mem_1_enable_o) begin
      if (mem_we_o) ram1[mem_addr_o] <= mem_data_o;
      else          ram1_q <= ram1[mem_addr_o];
    end
  end
  assign mem_0_data_i = ram0_q;
  assign mem_1_data_i = ram1_q;

  // Reference model state.
  typedef struct { int due; logic [WL-1:0] data; } rd_exp_t;
  rd_exp_t     rdq[$];
  bit [WL-1:0] mm0 [0:(1<<AW)-1];
  bit [WL-1:0] mm1 [0:(1<<AW)-1];
  logic          exp_wr_ack, exp_rd_ack, exp_en0, exp_en1, exp_we, exp_timeout, last_was_read;
  logic [AW-1:0] exp_addr;
  logic [WL-1:0] exp_data, exp_rd_data;
  int wr_wait, rd_wait, cyc;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_clear();
    rdq.delete();
    exp_wr_ack = 1'b0; exp_rd_ack = 1'b0; exp_en0 = 1'b0; exp_en1 = 1'b0; exp_we = 1'b0;
    exp_timeout = 1'b0; last_was_read = 1'b1;
    exp_addr = '0; exp_data = '0; exp_rd_data = '0;
    wr_wait = 0; rd_wait = 0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
    #1;
    check("rst_wr_ack", wr_ack_o, 0);     check("rst_rd_ack", rd_ack_o, 0);
    check("rst_rd_data", rd_data_o, 0);   check("rst_rd_valid", rd_valid_o, 0);
    check("rst_en0", mem_0_enable_o, 0);  check("rst_en1", mem_1_enable_o, 0);
    check("rst_we", mem_we_o, 0);         check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o, 0);     check("rst_timeout", timeout_o, 0);
    model_clear();
    @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    cyc++;
  endtask

  // One cycle: compare this cycle's outputs, then apply the arbitration rules to the inputs
  // presented now to predict the next cycle.
  task automatic tick();
    rd_exp_t head;
    logic exp_valid, access_now, pick_wr, to_next;
    exp_valid = 1'b0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      head = rdq.pop_front();
      exp_valid = 1'b1;
      exp_rd_data = head.data;
    end
    check("wr_ack", wr_ack_o, exp_wr_ack);    check("rd_ack", rd_ack_o, exp_rd_ack);
    check("en0", mem_0_enable_o, exp_en0);    check("en1", mem_1_enable_o, exp_en1);
    check("we", mem_we_o, exp_we);            check("mem_addr", mem_addr_o, exp_addr);
    check("mem_data", mem_data_o, exp_data);  check("rd_valid", rd_valid_o, exp_valid);
    check("rd_data", rd_data_o, exp_rd_data); check("timeout", timeout_o, exp_timeout);

    to_next = 1'b0;
    if (wr_req_i && !exp_wr_ack) begin
      wr_wait++;
      if (wr_wait > MAX_WAIT) to_next = 1'b1;
    end else wr_wait = 0;
    if (rd_req_i && !exp_rd_ack) begin
      rd_wait++;
      if (rd_wait > MAX_WAIT) to_next = 1'b1;
    end else rd_wait = 0;

    access_now = exp_wr_ack | exp_rd_ack;
    exp_wr_ack = 1'b0; exp_rd_ack = 1'b0; exp_en0 = 1'b0; exp_en1 = 1'b0; exp_we = 1'b0;
    if (!access_now && (wr_req_i || rd_req_i)) begin
      if (wr_req_i && rd_req_i) begin
`ifdef WRITE_PRIORITY_EN
        pick_wr = 1'b1;
`else
        pick_wr = last_was_read;
`endif
      end else pick_wr = wr_req_i;
      last_was_read = !pick_wr;
      if (pick_wr) begin
        exp_wr_ack = 1'b1; exp_we = 1'b1;
        exp_en0 = !wr_clip_i; exp_en1 = wr_clip_i;
        exp_addr = wr_addr_i; exp_data = wr_data_i;
        if (wr_clip_i) mm1[wr_addr_i] = wr_data_i;
        else           mm0[wr_addr_i] = wr_data_i;
      end else begin
        exp_rd_ack = 1'b1;
        exp_en0 = !rd_clip_i; exp_en1 = rd_clip_i;
        exp_addr = rd_addr_i;
        rdq.push_back('{cyc + 3, rd_clip_i ? mm1[rd_addr_i] : mm0[rd_addr_i]});
      end
    end
    exp_timeout = exp_timeout | to_next;
    @(posedge clock_i);
    @(negedge clock_i);
    cyc++;
  endtask

  initial begin
    logic wr_fin, rd_fin, e_wr, e_rd;
    reset_i = 1'b1;
    cyc = 0;
    model_clear();
    @(negedge clock_i);
    do_reset();

    // Preload clip 0 / 0x1FFFF with 0x1234 through the arbiter.
    wr_req_i = 1'b1; wr_clip_i = 1'b0; wr_addr_i = 17'h1FFFF; wr_data_i = 16'h1234;
    tick(); tick();
    wr_req_i = 1'b0; tick();

    // Single write to clip 1.
    wr_req_i = 1'b1; wr_clip_i = 1'b1; wr_addr_i = 17'h00005; wr_data_i = 16'hBEEF;
    tick();
    check("sw_en1", mem_1_enable_o, 1);      check("sw_we", mem_we_o, 1);
    check("sw_addr", mem_addr_o, 17'h00005); check("sw_data", mem_data_o, 16'hBEEF);
    check("sw_ack", wr_ack_o, 1);
    tick();
    wr_req_i = 1'b0; tick();

    // Single read from clip 0 / 0x1FFFF.
    rd_req_i = 1'b1; rd_clip_i = 1'b0; rd_addr_i = 17'h1FFFF;
    tick();
    check("sr_ack", rd_ack_o, 1); check("sr_we", mem_we_o, 0); check("sr_en0", mem_0_enable_o, 1);
    tick();
    rd_req_i = 1'b0; tick();
    check("sr_valid", rd_valid_o, 1); check("sr_data", rd_data_o, 16'h1234);
    tick();

    // Write then read of the same clip 1 location, requested together.
    wr_req_i = 1'b1; wr_clip_i = 1'b1; wr_addr_i = 17'h00010; wr_data_i = 16'hA5A5;
    rd_req_i = 1'b1; rd_clip_i = 1'b1; rd_addr_i = 17'h00010;
    tick();
    check("wr_first", wr_ack_o, 1);
    tick();
    wr_req_i = 1'b0; tick();
    tick();
    rd_req_i = 1'b0; tick();
    check("raw_valid", rd_valid_o, 1); check("raw_data", rd_data_o, 16'hA5A5);
    tick();

    // Both requesters saturating.
    wr_req_i = 1'b1; wr_clip_i = 1'b0; wr_addr_i = 17'h00020; wr_data_i = 16'h0100;
    rd_req_i = 1'b1; rd_clip_i = 1'b0; rd_addr_i = 17'h00002;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
`ifdef WRITE_PRIORITY_EN
        e_wr = (k % 2 == 1); e_rd = 1'b0;
`else
        e_wr = (k % 4 == 1); e_rd = (k % 4 == 3);
`endif
        check("sat_wr_ack", wr_ack_o, e_wr);
        check("sat_rd_ack", rd_ack_o, e_rd);
        if (e_wr) wr_fin = 1'b1;
        else if (wr_fin) begin wr_data_i = wr_data_i + 16'h0001; wr_fin = 1'b0; end
      end else wr_fin = 1'b0;
      tick();
    end
`ifdef WRITE_PRIORITY_EN
    check("sat_timeout", timeout_o, 1);
`else
    check("sat_timeout", timeout_o, 0);
`endif
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    repeat (4) tick();

    // Reset during a read ACCESS: the in-flight read must never return.
    rd_req_i = 1'b1; rd_clip_i = 1'b0; rd_addr_i = 17'h00003;
    tick();
    check("mid_rd_ack", rd_ack_o, 1);
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("post_rst_valid", rd_valid_o, 0);
      tick();
    end

    // Randomized traffic.
    wr_fin = 1'b0; rd_fin = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (wr_fin) begin
        wr_fin = 1'b0;
        wr_req_i = ($urandom_range(0, 1) == 0);
        wr_clip_i = $urandom_range(0, 1); wr_addr_i = 17'($urandom_range(0, 7));
        wr_data_i = 16'($urandom);
      end else if (exp_wr_ack) wr_fin = 1'b1;
      else if (wr_req_i) begin
        if ($urandom_range(0, 15) == 0) wr_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        wr_req_i = 1'b1;
        wr_clip_i = $urandom_range(0, 1); wr_addr_i = 17'($urandom_range(0, 7));
        wr_data_i = 16'($urandom);
      end
      if (rd_fin) begin
        rd_fin = 1'b0;
        rd_req_i = ($urandom_range(0, 1) == 0);
        rd_clip_i = $urandom_range(0, 1); rd_addr_i = 17'($urandom_range(0, 7));
      end else if (exp_rd_ack) rd_fin = 1'b1;
      else if (rd_req_i) begin
        if ($urandom_range(0, 15) == 0) rd_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rd_req_i = 1'b1;
        rd_clip_i = $urandom_range(0, 1); rd_addr_i = 17'($urandom_range(0, 7));
      end
      tick();
    end
    wr_req_i = 1'b0; rd_req_i = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
